// File: rtl/dual_byte_seg_display.sv
// ============================================================================
//  Module      : dual_byte_seg_display
//  Description : Captures two bytes on a load strobe and converts each one to
//                three BCD digits with a shared-timing double-dabble engine.
//                The results drive a 6-digit multiplexed, active-low 7-segment
//                display (val_a on the left, val_b on the right).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dual_byte_seg_display #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] val_a,
  input  logic [7:0] val_b,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [5:0] an
);

  localparam int unsigned C_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]         bin_a_q, bin_b_q;
  logic [9:0]         bcd_a_q, bcd_b_q;
  logic [2:0]         iter_q;
  logic [11:0]        disp_a_q, disp_b_q;   // {hundreds, tens, ones}
  logic               done_q;
  logic [C_DIV_W-1:0] div_q;
  logic [2:0]         idx_q, idx_d;
  logic [5:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic [17:0]        step_a, step_b;

  // One double-dabble iteration: correct ones/tens digits, then shift the
  // combined {bcd, bin} register left. The hundreds digit never exceeds 2,
  // so it never needs correction and bit 9 of the accumulator is dropped.
  function automatic logic [17:0] dabble_step(input logic [8:0] bcd,
                                              input logic [7:0] bin);
    logic [7:0] lo;
    lo = bcd[7:0];
    if (lo[3:0] >= 4'd5) lo[3:0] = lo[3:0] + 4'd3;
    if (lo[7:4] >= 4'd5) lo[7:4] = lo[7:4] + 4'd3;
    return {bcd[8], lo, bin, 1'b0};
  endfunction

  // Active-low segment patterns {g,f,e,d,c,b,a}; non-decimal codes are blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign step_a = dabble_step(bcd_a_q[8:0], bin_a_q);
  assign step_b = dabble_step(bcd_b_q[8:0], bin_b_q);

  // Conversion state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: capture only from IDLE, eight shift iterations, then
  // a single DONE cycle that publishes the digits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load) state_d = ST_SHIFT;
      ST_SHIFT: if (iter_q == 3'd7) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Conversion datapath and display registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_a_q  <= '0;
      bin_b_q  <= '0;
      bcd_a_q  <= '0;
      bcd_b_q  <= '0;
      iter_q   <= '0;
      disp_a_q <= '0;
      disp_b_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            bin_a_q <= val_a;
            bin_b_q <= val_b;
            bcd_a_q <= '0;
            bcd_b_q <= '0;
            iter_q  <= '0;
          end
        end
        ST_SHIFT: begin
          bcd_a_q <= step_a[17:8];
          bin_a_q <= step_a[7:0];
          bcd_b_q <= step_b[17:8];
          bin_b_q <= step_b[7:0];
          iter_q  <= iter_q + 3'd1;
        end
        ST_DONE: begin
          disp_a_q <= {2'b00, bcd_a_q};
          disp_b_q <= {2'b00, bcd_b_q};
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pattern for the digit the scan moves to next, with leading-zero blanking.
  always_comb begin
    logic [3:0] dig;
    logic       blank;
    dig   = 4'd0;
    blank = 1'b0;
    idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    case (idx_d)
      3'd0: dig = disp_b_q[3:0];
      3'd1: begin
        dig   = disp_b_q[7:4];
        blank = BLANK_LZ && (disp_b_q[11:8] == 4'd0) && (disp_b_q[7:4] == 4'd0);
      end
      3'd2: begin
        dig   = disp_b_q[11:8];
        blank = BLANK_LZ && (disp_b_q[11:8] == 4'd0);
      end
      3'd3: dig = disp_a_q[3:0];
      3'd4: begin
        dig   = disp_a_q[7:4];
        blank = BLANK_LZ && (disp_a_q[11:8] == 4'd0) && (disp_a_q[7:4] == 4'd0);
      end
      3'd5: begin
        dig   = disp_a_q[11:8];
        blank = BLANK_LZ && (disp_a_q[11:8] == 4'd0);
      end
      default: dig = 4'd0;
    endcase
    an_d  = ~(6'b000001 << idx_d);
    seg_d = blank ? 7'b1111111 : seg7(dig);
  end

  // Scan divider; index, anode and segment registers advance together on wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= 6'b111110;
      seg_q <= 7'b1000000;
    end else if (div_q == C_DIV_W'(SCAN_DIV - 1)) begin
      div_q <= '0;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end else begin
      div_q <= div_q + C_DIV_W'(1);
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_byte_seg_display.sv
// ============================================================================
//  Module      : tb_dual_byte_seg_display
//  Description : Directed self-checking bench for dual_byte_seg_display. Two
//                instances share stimulus: one with leading-zero blanking,
//                one without.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dual_byte_seg_display;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] val_a = 8'd0;
  logic [7:0] val_b = 8'd0;
  logic       busy, done, busy_nb, done_nb;
  logic [6:0] seg, seg_nb;
  logic [5:0] an, an_nb;

  int checks = 0;
  int errors = 0;

  dual_byte_seg_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .val_a(val_a), .val_b(val_b), .load(load),
    .busy(busy), .done(done), .seg(seg), .an(an)
  );

  dual_byte_seg_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .val_a(val_a), .val_b(val_b), .load(load),
    .busy(busy_nb), .done(done_nb), .seg(seg_nb), .an(an_nb)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b1000000;
      1: pat = 7'b1111001;
      2: pat = 7'b0100100;
      3: pat = 7'b0110000;
      4: pat = 7'b0011001;
      5: pat = 7'b0010010;
      6: pat = 7'b0000010;
      7: pat = 7'b1111000;
      8: pat = 7'b0000000;
      9: pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
  endfunction

  // pos 0 = ones, 1 = tens, 2 = hundreds
  function automatic logic [6:0] exp_seg(input int v, input int pos, input bit blz);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (pos)
      0:       exp_seg = pat(o);
      1:       exp_seg = (blz && t == 0 && h == 0) ? 7'b1111111 : pat(t);
      default: exp_seg = (blz && h == 0) ? 7'b1111111 : pat(h);
    endcase
  endfunction

  // Align to the first cycle of index 0, then sample each digit of one frame.
  task automatic check_frame(input string tag, input int a, input int b);
    int n;
    int v;
    logic [5:0] ea;
    n = 0;
    while (an == 6'b111110 && n < 40) begin @(negedge clk); n++; end
    while (an != 6'b111110 && n < 80) begin @(negedge clk); n++; end
    chk({tag, "_sync"}, 32'(n < 80), 32'd1);
    for (int i = 0; i < 6; i++) begin
      v  = (i < 3) ? b : a;
      ea = ~(6'b000001 << i);
      chk($sformatf("%s_an%0d", tag, i), 32'(an), 32'(ea));
      chk($sformatf("%s_seg%0d", tag, i), 32'(seg), 32'(exp_seg(v, i % 3, 1'b1)));
      chk($sformatf("%s_segnb%0d", tag, i), 32'(seg_nb), 32'(exp_seg(v, i % 3, 1'b0)));
      repeat (SD) @(negedge clk);
    end
  endtask

  // Single-cycle load; observe busy/done for the following 14 cycles.
  task automatic do_load(input logic [7:0] a, input logic [7:0] b,
                         output int busy_cyc, output int done_cnt, output int done_at);
    @(negedge clk);
    val_a = a;
    val_b = b;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    busy_cyc = 0;
    done_cnt = 0;
    done_at  = 0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; done_at = n; end
    end
  endtask

  initial begin
    int bc, dc, da;

    // Reset, then three idle cycles.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_an",   32'(an),   32'h3E);
    chk("rst_seg",  32'(seg),  32'h40);
    check_frame("rst_frame", 0, 0);

    // 175 / 174: latency and pulse shape.
    do_load(8'd175, 8'd174, bc, dc, da);
    chk("l1_busy_cycles", 32'(bc), 32'd9);
    chk("l1_done_count",  32'(dc), 32'd1);
    chk("l1_done_cycle",  32'(da), 32'd10);
    check_frame("f175_174", 175, 174);

    // Extremes.
    do_load(8'd255, 8'd0, bc, dc, da);
    chk("l2_done_count", 32'(dc), 32'd1);
    check_frame("f255_0", 255, 0);

    // Leading-zero blanking versus plain zeros.
    do_load(8'd7, 8'd40, bc, dc, da);
    chk("l3_done_count", 32'(dc), 32'd1);
    check_frame("f7_40", 7, 40);

    // Second load while busy must be ignored, as must the changed inputs.
    @(negedge clk);
    val_a = 8'd99;
    val_b = 8'd3;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    dc = 0;
    da = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin dc++; da = n; end
      if (n == 3) begin
        chk("busy_at_reload", 32'(busy), 32'd1);
        val_a = 8'd12;
        val_b = 8'd88;
        load  = 1'b1;
      end
      if (n == 4) load = 1'b0;
    end
    chk("reload_done_count", 32'(dc), 32'd1);
    chk("reload_done_cycle", 32'(da), 32'd10);
    check_frame("f99_3", 99, 3);

    // Reset in the 4th SHIFT cycle aborts and clears the display.
    @(negedge clk);
    val_a = 8'd200;
    val_b = 8'd51;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    dc = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("abort_no_done", 32'(dc), 32'd0);
    check_frame("f_abort", 0, 0);

    // Fresh conversion after the abort.
    do_load(8'd123, 8'd45, bc, dc, da);
    chk("l5_busy_cycles", 32'(bc), 32'd9);
    chk("l5_done_count",  32'(dc), 32'd1);
    check_frame("f123_45", 123, 45);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dual_byte_seg_display.md
Name: dual_byte_seg_display

Overview:
- Downstream consumer of the 8-bit adder stage: captures its two byte results (sum and operand) on a load strobe.
- Converts each byte to 3 BCD digits with a sequential double-dabble engine.
- Drives a 6-digit multiplexed active-low 7-segment display: left 3 digits show val_a, right 3 digits show val_b.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit before the scan advances (must be ≥2).
- BLANK_LZ, 1, 1 blanks leading zeros in the hundreds and tens digits; 0 shows all digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- val_a  input  8  sum byte from the adder stage (unsigned 0..255).
- val_b  input  8  operand byte from the adder stage (unsigned 0..255).
- load  input  1  capture strobe; acted on only in IDLE.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the new digits reach the display.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  6  digit enables, active-low; an[0] = rightmost digit.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, busy=0, done=0.
  - All six displayed digits = 0; scan index=0; divider=0.
  - an=6'b111110; seg=7'b1000000 ('0').
  - Reset overrides everything, including a conversion in progress. Partial results are discarded and the displayed digits return to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If load=1 at edge k: latch val_a and val_b into shift registers, clear the BCD accumulators and the iteration count, go to SHIFT, busy=1 from edge k.
  - Otherwise stay in IDLE.
- SHIFT: one iteration per edge on both bytes in parallel.
  - In each 4-bit BCD digit, add 3 if the digit ≥5.
  - Then shift {bcd, bin} left by 1.
  - After 8 iterations (edges k+1..k+8) go to DONE.
- DONE, at edge k+9:
  - Copy both 3-digit results into the display registers.
  - done=1 for exactly the cycle after edge k+9.
  - busy=0 and state returns to IDLE.
- Total latency from load to display update: 9 edges.
- load while busy=1 is ignored: no queueing, inputs not re-sampled.
- load=1 on the same edge that DONE exits is also ignored; a new capture needs load=1 in IDLE.
- val_a/val_b changes outside the capture edge have no effect.
- Display regs change only at DONE exit or reset; the scan reads them continuously.
- Scan:
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the index advances 0→1→…→5→0.
  - an and seg are registered and update on the same edge as the index.
  - Exactly one an bit is low at all times.
- Digit map:
  - index 0/1/2 = val_b ones/tens/hundreds.
  - index 3/4/5 = val_a ones/tens/hundreds.
- Decoder patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Blanking (BLANK_LZ=1):
  - Hundreds is blanked if 0.
  - Tens is blanked if tens=0 and hundreds=0.
  - Ones is never blanked.
- Arithmetic: unsigned only, max 255 → 3 digits with no overflow. The BCD accumulator is 10 bits (hundreds digit ≤2).

Test Plan:
- Reset then idle 3 cycles → busy=0, done=0, an=111110, seg=1000000; with SCAN_DIV=4, seg is blank at indices 1,2,4,5 and '0' at index 3.
- load=1 one cycle with val_a=175, val_b=174 → busy high for 9 cycles, done pulses once on cycle 10. Scan (SCAN_DIV=4) then shows the digit stream 4,7,1,5,7,1: seg 0011001,1111000,1111001,0010010,1111000,1111001. Each an bit is low for 4 cycles; full frame is 24 cycles.
- val_a=255, val_b=0, load → index 5..3 = 2,5,5; indices 2,1 blank; index 0 = '0'.
- val_a=7, val_b=40, BLANK_LZ=1 → val_a shows blank,blank,'7'; val_b shows blank,'4','0'. With BLANK_LZ=0 → '0','0','7' and '0','4','0'.
- load (val_a=99) then a second load (val_a=12) 3 cycles later while busy → display shows 99 and only one done pulse occurs.
- load (val_a=200), then rst_n=0 at the 4th SHIFT cycle → busy=0 next cycle, all digits 0, no done pulse. A fresh load after reset converts correctly.
